mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, max cycles dmem_req is held without dmem_ack before the access is aborted.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  EXE-stage result valid this cycle.
REQ-005 mem_read  input  1  instruction is a word load.
REQ-006 mem_write  input  1  instruction is a word store.
REQ-007 reg_write  input  1  instruction writes the register file.
REQ-008 alu_result  input  32  ALU result; byte address for loads/stores.
REQ-009 alu_overflow  input  1  ALU signed overflow flag.
REQ-010 store_data  input  32  rt operand for stores.
REQ-011 write_addr  input  5  destination register.
REQ-012 stall  output  1  upstream holds inputs and pipeline while high.
REQ-013 dmem_req, dmem_we  output  1 each  memory request, write enable.
REQ-014 dmem_addr, dmem_wdata  output  32 each  word address (byte address, [1:0]=0), store data.
REQ-015 dmem_ack  input  1  memory completes the request this cycle.
REQ-016 dmem_rdata  input  32  load data, valid when dmem_ack=1.
REQ-017 wb_valid, wb_reg_write  output  1 each  write-back valid, register write enable.
REQ-018 wb_addr  output  5; wb_data  output  32  write-back destination and data.
REQ-019 err_misalign, err_ovf, err_timeout  output  1 each  one-cycle error pulses, coincident with the related wb_valid.

Function
REQ-020 FSM states: IDLE, REQ; reset state IDLE.
REQ-021 IDLE, in_valid=1, non-memory op: next cycle wb_valid=1, wb_data=alu_result, wb_addr=write_addr, wb_reg_write=reg_write; latency 1; stay IDLE.
REQ-022 IDLE, in_valid=1, memory op, alu_result[1:0]=00: latch address, store_data, write_addr, type; go to REQ.
REQ-023 mem_read and mem_write both high: treat as load; mem_write ignored.
REQ-024 REQ: dmem_req=1, dmem_we=(store), dmem_addr and dmem_wdata stable from latched values until the ack cycle inclusive.
REQ-025 stall = (state==REQ), asserted through the ack cycle inclusive; in_valid ignored while in REQ.
REQ-026 dmem_ack=1 in REQ: capture dmem_rdata; next cycle wb_valid=1, return to IDLE, dmem_req=0.
REQ-027 Load completion: wb_data=captured rdata, wb_reg_write=reg_write latched; store completion: wb_reg_write=0, wb_data=latched address.
REQ-028 Latency: load/store with ack in first REQ cycle gives wb_valid 2 cycles after acceptance; each extra wait cycle adds 1.
REQ-029 Wait counter: cleared on REQ entry, +1 per REQ cycle without ack; count reaching ACK_TIMEOUT with dmem_ack=0 -> drop dmem_req, IDLE, next cycle wb_valid=1, wb_reg_write=0, err_timeout=1.
REQ-030 Ack arriving in the timeout cycle: ack wins, normal completion, no err_timeout.
REQ-031 Memory op with alu_result[1:0]!=00: no dmem_req, stay IDLE, next cycle wb_valid=1, wb_reg_write=0, err_misalign=1.
REQ-032 Non-memory op with alu_overflow=1 and reg_write=1: next cycle wb_valid=1, wb_reg_write=0, err_ovf=1; overflow ignored for memory ops.
REQ-033 wb_addr=0: wb_reg_write forced 0 on every path.
REQ-034 wb_* and err_* are registered outputs, 1-cycle pulses; zero when no completion that cycle.
REQ-035 dmem_ack outside REQ: ignored.

Reset
REQ-036 rst_n=0 forces immediately: state IDLE, counter 0, stall=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_reg_write=0, wb_addr=0, wb_data=0, all err_*=0.
REQ-037 Reset during REQ aborts the access with no write-back; first accepted op after release behaves per REQ-021/022.

Verification
REQ-038 ALU op alu_result=0x0000_0005, write_addr=3, reg_write=1 -> next cycle wb_valid=1, wb_addr=3, wb_data=5, stall never high.
REQ-039 Load addr 0x100, write_addr=8, ack after 3 wait cycles with rdata=0xDEAD_BEEF -> dmem_req/stall high 4 cycles, then wb_data=0xDEAD_BEEF, wb_reg_write=1.
REQ-040 Store addr 0x104, store_data=0x1234, ack same cycle as first REQ -> dmem_we=1, dmem_wdata=0x1234, wb_valid with wb_reg_write=0.
REQ-041 Load addr 0x102 -> no dmem_req, next cycle err_misalign=1, wb_reg_write=0.
REQ-042 Load with no ack, ACK_TIMEOUT=16 -> dmem_req drops after 16 REQ cycles, err_timeout=1; repeat with ack on cycle 16 -> normal completion.
REQ-043 rst_n low mid-REQ -> dmem_req and stall low same cycle, no wb_valid after release; ALU op with overflow and reg_write=1 -> err_ovf=1, wb_reg_write=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes ALU results through and performs word loads/stores over a
// req/ack memory bus, with misalignment, overflow and ack-timeout error reporting.
module mem_stage #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               reg_write,
  input  logic [31:0]        alu_result,
  input  logic               alu_overflow,
  input  logic [31:0]        store_data,
  input  logic [4:0]         write_addr,
  output logic               stall,
  mem_stage_if.master        dmem,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [4:0]         wb_addr,
  output logic [31:0]        wb_data,
  output logic               err_misalign,
  output logic               err_ovf,
  output logic               err_timeout
);

  // Counter only has to hold 0 .. ACK_TIMEOUT-1.
  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [4:0]      waddr_q, waddr_d;
  logic            is_load_q, is_load_d;
  logic            rw_q, rw_d;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_rw_q, wb_rw_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            err_mis_q, err_mis_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_to_q, err_to_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    is_load_d  = is_load_q;
    rw_d       = rw_q;
    wb_valid_d = 1'b0;
    wb_rw_d    = 1'b0;
    wb_addr_d  = '0;
    wb_data_d  = '0;
    err_mis_d  = 1'b0;
    err_ovf_d  = 1'b0;
    err_to_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (mem_read || mem_write) begin
            if (alu_result[1:0] != 2'b00) begin
              wb_valid_d = 1'b1;
              wb_addr_d  = write_addr;
              wb_data_d  = alu_result;
              err_mis_d  = 1'b1;
            end else begin
              state_d   = StReq;
              cnt_d     = '0;
              addr_d    = alu_result;
              wdata_d   = store_data;
              waddr_d   = write_addr;
              is_load_d = mem_read;  // load wins when both are set
              rw_d      = reg_write;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_addr_d  = write_addr;
            wb_data_d  = alu_result;
            if (alu_overflow && reg_write) begin
              err_ovf_d = 1'b1;
            end else begin
              wb_rw_d = reg_write;
            end
          end
        end
      end
      StReq: begin
        if (dmem.dmem_ack) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_addr_d  = waddr_q;
          if (is_load_q) begin
            wb_data_d = dmem.dmem_rdata;
            wb_rw_d   = rw_q;
          end else begin
            wb_data_d = addr_q;
          end
        end else if (cnt_q == CntLast) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_addr_d  = waddr_q;
          wb_data_d  = addr_q;
          err_to_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // r0 is hardwired; never request a write to it.
    if (wb_addr_d == 5'd0) begin
      wb_rw_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      is_load_q  <= 1'b0;
      rw_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_mis_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      is_load_q  <= is_load_d;
      rw_q       <= rw_d;
      wb_valid_q <= wb_valid_d;
      wb_rw_q    <= wb_rw_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_mis_q  <= err_mis_d;
      err_ovf_q  <= err_ovf_d;
      err_to_q   <= err_to_d;
    end
  end

  logic in_req;
  assign in_req = (state_q == StReq);

  assign stall           = in_req;
  assign dmem.dmem_req   = in_req;
  assign dmem.dmem_we    = in_req && !is_load_q;
  assign dmem.dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_wdata = in_req ? wdata_q : 32'd0;

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign err_misalign = err_mis_q;
  assign err_ovf      = err_ovf_q;
  assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the bench drives the memory bus by hand.
module tb_mem_stage;
  logic        clk;
  logic        rst_n;
  logic        in_valid, mem_read, mem_write, reg_write, alu_overflow;
  logic [31:0] alu_result, store_data;
  logic [4:0]  write_addr;
  logic        stall, wb_valid, wb_reg_write, err_misalign, err_ovf, err_timeout;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mem_stage_if dmem ();

  mem_stage #(.ACK_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .store_data   (store_data),
    .write_addr   (write_addr),
    .stall        (stall),
    .dmem         (dmem.master),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .err_misalign (err_misalign),
    .err_ovf      (err_ovf),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    alu_overflow = 1'b0;
    alu_result   = '0;
    store_data   = '0;
    write_addr   = '0;
  endtask

  // Present one op for a single cycle; returns #1 after the accepting edge.
  task automatic issue(input logic rd, input logic wr, input logic rw, input logic ovf,
                       input logic [31:0] res, input logic [31:0] sd, input logic [4:0] wa);
    in_valid     = 1'b1;
    mem_read     = rd;
    mem_write    = wr;
    reg_write    = rw;
    alu_overflow = ovf;
    alu_result   = res;
    store_data   = sd;
    write_addr   = wa;
    step();
    clear_in();
  endtask

  initial begin
    clear_in();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    rst_n = 1'b0;
    #3;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("rst_dmem_addr", dmem.dmem_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // ALU pass-through, latency 1
    in_valid = 1'b1; reg_write = 1'b1; alu_result = 32'h5; write_addr = 5'd3;
    chk("alu_stall_pre", {31'd0, stall}, 32'd0);
    step();
    clear_in();
    chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu_wb_addr", {27'd0, wb_addr}, 32'd3);
    chk("alu_wb_data", wb_data, 32'h5);
    chk("alu_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    step();
    chk("alu_pulse_end", {31'd0, wb_valid}, 32'd0);

    // Load with three wait cycles
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 5'd8);
    for (int i = 0; i < 4; i++) begin
      chk("ld_req", {31'd0, dmem.dmem_req}, 32'd1);
      chk("ld_stall", {31'd0, stall}, 32'd1);
      chk("ld_addr", dmem.dmem_addr, 32'h100);
      chk("ld_we", {31'd0, dmem.dmem_we}, 32'd0);
      chk("ld_no_wb", {31'd0, wb_valid}, 32'd0);
      if (i == 3) begin
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    chk("ld_req_drop", {31'd0, dmem.dmem_req}, 32'd0);
    chk("ld_stall_drop", {31'd0, stall}, 32'd0);
    chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    chk("ld_wb_addr", {27'd0, wb_addr}, 32'd8);

    // Store acked in the first REQ cycle
    issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h1234, 5'd5);
    chk("st_we", {31'd0, dmem.dmem_we}, 32'd1);
    chk("st_wdata", dmem.dmem_wdata, 32'h1234);
    chk("st_addr", dmem.dmem_addr, 32'h104);
    dmem.dmem_ack = 1'b1;
    step();
    dmem.dmem_ack = 1'b0;
    chk("st_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("st_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("st_wb_data", wb_data, 32'h104);

    // Misaligned load
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 5'd9);
    chk("mis_no_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("mis_err", {31'd0, err_misalign}, 32'd1);
    chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    step();
    chk("mis_err_pulse", {31'd0, err_misalign}, 32'd0);

    // Timeout: 16 REQ cycles, no ack
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 5'd4);
    for (int i = 0; i < 16; i++) begin
      chk("to_req_held", {31'd0, dmem.dmem_req}, 32'd1);
      step();
    end
    chk("to_req_drop", {31'd0, dmem.dmem_req}, 32'd0);
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("to_wb_rw", {31'd0, wb_reg_write}, 32'd0);

    // Ack in the timeout cycle wins
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 5'd4);
    for (int i = 0; i < 16; i++) begin
      chk("ta_req_held", {31'd0, dmem.dmem_req}, 32'd1);
      if (i == 15) begin
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hCAFE_0001;
      end
      step();
    end
    dmem.dmem_ack = 1'b0;
    chk("ta_no_err", {31'd0, err_timeout}, 32'd0);
    chk("ta_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ta_wb_data", wb_data, 32'hCAFE_0001);
    chk("ta_wb_rw", {31'd0, wb_reg_write}, 32'd1);

    // Stray ack in IDLE
    dmem.dmem_ack = 1'b1;
    step();
    dmem.dmem_ack = 1'b0;
    chk("stray_ack_wb", {31'd0, wb_valid}, 32'd0);
    chk("stray_ack_req", {31'd0, dmem.dmem_req}, 32'd0);

    // Read and write both set: treated as load
    issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h108, 32'h77, 5'd6);
    chk("rw_both_we", {31'd0, dmem.dmem_we}, 32'd0);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h55;
    step();
    dmem.dmem_ack = 1'b0;
    chk("rw_both_data", wb_data, 32'h55);
    chk("rw_both_rw", {31'd0, wb_reg_write}, 32'd1);

    // Write to r0 suppressed
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h9, 32'h0, 5'd0);
    chk("r0_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("r0_wb_rw", {31'd0, wb_reg_write}, 32'd0);

    // Reset mid-REQ aborts with no write-back
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h10C, 32'h0, 5'd2);
    chk("rr_req", {31'd0, dmem.dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_req_drop", {31'd0, dmem.dmem_req}, 32'd0);
    chk("rr_stall_drop", {31'd0, stall}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_no_wb", {31'd0, wb_valid}, 32'd0);
    end

    // ALU overflow with reg_write
    issue(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 5'd7);
    chk("ovf_err", {31'd0, err_ovf}, 32'd1);
    chk("ovf_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("ovf_wb_rw", {31'd0, wb_reg_write}, 32'd0);

    // Overflow ignored for memory ops
    issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h110, 32'hAB, 5'd1);
    chk("ovf_mem_req", {31'd0, dmem.dmem_req}, 32'd1);
    chk("ovf_mem_no_err", {31'd0, err_ovf}, 32'd0);
    dmem.dmem_ack = 1'b1;
    step();
    dmem.dmem_ack = 1'b0;
    chk("ovf_mem_wb", {31'd0, wb_valid}, 32'd1);
    chk("ovf_mem_no_err2", {31'd0, err_ovf}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
